// File: rtl/noc_host_bridge_if.sv
// Host/mesh handshake bundle for noc_host_bridge.
// Signal directions in the names are as seen from the bridge: the bridge
// uses the slave modport, and the host/mesh side uses the master modport.
interface noc_host_bridge_if #(
  parameter int unsigned data_width  = 256,
  parameter int unsigned total_width = 274
);
  // Host side
  logic                   i_valid_pci;
  logic [data_width-1:0]  i_data_pci;
  logic                   o_ready_pci;
  logic                   o_valid_pci;
  logic [data_width-1:0]  o_data_pci;
  logic                   i_ready_pci;
  // Mesh side
  logic                   o_valid_noc;
  logic [total_width-1:0] o_data_noc;
  logic                   i_ready_noc;
  logic                   i_valid_noc;
  logic [total_width-1:0] i_data_noc;
  logic                   o_ready_noc;

  modport slave (
    input  i_valid_pci, i_data_pci, i_ready_pci, i_ready_noc, i_valid_noc, i_data_noc,
    output o_ready_pci, o_valid_pci, o_data_pci, o_valid_noc, o_data_noc, o_ready_noc
  );

  modport master (
    output i_valid_pci, i_data_pci, i_ready_pci, i_ready_noc, i_valid_noc, i_data_noc,
    input  o_ready_pci, o_valid_pci, o_data_pci, o_valid_noc, o_data_noc, o_ready_noc
  );
endinterface

// File: rtl/noc_host_bridge.sv
// Host-to-mesh bridge at tile (0,0). Host words become flits sent round-robin
// to every worker tile; results come back through a credit-bounded buffer.
// BRIDGE_REORDER_EN defined: results return in issue order via a reorder buffer.
// BRIDGE_REORDER_EN undefined: results return in arrival order via a FIFO.
module noc_host_bridge #(
  parameter int unsigned X           = 8,
  parameter int unsigned Y           = 8,
  parameter int unsigned pck_num     = 12,
  parameter int unsigned data_width  = 256,
  parameter int unsigned x_size      = $clog2(X),
  parameter int unsigned y_size      = $clog2(Y),
  parameter int unsigned total_width = x_size + y_size + pck_num + data_width,
  parameter int unsigned ROB_DEPTH   = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  noc_host_bridge_if.slave           bus,
  output logic [$clog2(ROB_DEPTH):0] o_outstanding,
  output logic                       o_err
);
  localparam int unsigned AW = $clog2(ROB_DEPTH);
  localparam int unsigned OW = AW + 1;
  localparam logic [x_size-1:0] XLast  = x_size'(X - 1);
  localparam logic [y_size-1:0] YLast  = y_size'(Y - 1);
  // First worker tile in row-major order; (0,0) is the bridge itself.
  localparam logic [x_size-1:0] XFirst = (X > 1) ? x_size'(1) : '0;
  localparam logic [y_size-1:0] YFirst = (X > 1) ? '0 : y_size'(1);

  logic                   r_valid_noc;
  logic [total_width-1:0] r_data_noc;
  logic [pck_num-1:0]     r_seq;
  logic [x_size-1:0]      r_dx;
  logic [y_size-1:0]      r_dy;
  logic [OW-1:0]          r_outstanding;
  logic                   r_err;

  logic                   w_ready_pci;
  logic                   w_in_acc;
  logic                   w_out_acc;
  logic                   w_in_err;
  logic [x_size-1:0]      w_nx;
  logic [y_size-1:0]      w_ny;

  assign w_ready_pci = (r_outstanding < OW'(ROB_DEPTH)) && (!r_valid_noc || bus.i_ready_noc);
  assign w_in_acc    = bus.i_valid_pci && w_ready_pci;
  assign w_out_acc   = bus.o_valid_pci && bus.i_ready_pci;

  assign bus.o_ready_pci = w_ready_pci;
  assign bus.o_valid_noc = r_valid_noc;
  assign bus.o_data_noc  = r_data_noc;
  assign o_outstanding   = r_outstanding;
  assign o_err           = r_err;

  // Next destination: row-major step, skipping the bridge tile on wrap.
  always_comb begin
    w_nx = r_dx + x_size'(1);
    w_ny = r_dy;
    if (r_dx == XLast) begin
      w_nx = '0;
      w_ny = (r_dy == YLast) ? '0 : r_dy + y_size'(1);
    end
    if ((w_nx == '0) && (w_ny == '0)) begin
      w_nx = XFirst;
      w_ny = YFirst;
    end
  end

  // Ingress: register the stamped flit and advance seq/destination per accept.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid_noc <= 1'b0;
      r_data_noc  <= '0;
      r_seq       <= '0;
      r_dx        <= XFirst;
      r_dy        <= YFirst;
    end else if (w_in_acc) begin
      r_valid_noc <= 1'b1;
      r_data_noc  <= {r_dx, r_dy, r_seq, bus.i_data_pci};
      r_seq       <= r_seq + pck_num'(1);
      r_dx        <= w_nx;
      r_dy        <= w_ny;
    end else if (bus.i_ready_noc) begin
      r_valid_noc <= 1'b0;
    end
  end

  // Credits: one per packet between host accept and host delivery.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_outstanding <= '0;
    end else if (w_in_acc && !w_out_acc) begin
      r_outstanding <= r_outstanding + OW'(1);
    end else if (!w_in_acc && w_out_acc) begin
      r_outstanding <= r_outstanding - OW'(1);
    end
  end

  // Sticky protocol error, cleared only by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_err <= 1'b0;
    end else if (w_in_err) begin
      r_err <= 1'b1;
    end
  end

`ifdef BRIDGE_REORDER_EN
  logic [data_width-1:0] r_rob_data [ROB_DEPTH];
  logic [ROB_DEPTH-1:0]  r_rob_vld;
  logic [pck_num-1:0]    r_rd_seq;
  logic [AW-1:0]         w_wr_idx;
  logic [AW-1:0]         w_hd_idx;
  logic                  w_wr_en;
  logic                  w_unused_flit;

  // Slot is the low bits of the returned seq; source x/y are ignored.
  assign w_wr_idx      = bus.i_data_noc[data_width +: AW];
  assign w_hd_idx      = r_rd_seq[AW-1:0];
  assign w_in_err      = bus.i_valid_noc && r_rob_vld[w_wr_idx];
  assign w_wr_en       = bus.i_valid_noc && !r_rob_vld[w_wr_idx];
  assign w_unused_flit = ^bus.i_data_noc[total_width-1:data_width+AW];

  assign bus.o_ready_noc = 1'b1;
  assign bus.o_valid_pci = r_rob_vld[w_hd_idx];
  assign bus.o_data_pci  = r_rob_data[w_hd_idx];

  // Valid bits and head pointer; a write can never hit the slot being
  // cleared because a write needs the slot empty and a clear needs it full.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rob_vld <= '0;
      r_rd_seq  <= '0;
    end else begin
      if (w_wr_en) begin
        r_rob_vld[w_wr_idx] <= 1'b1;
      end
      if (w_out_acc) begin
        r_rob_vld[w_hd_idx] <= 1'b0;
        r_rd_seq            <= r_rd_seq + pck_num'(1);
      end
    end
  end

  // Payload storage, qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_rob_data[w_wr_idx] <= bus.i_data_noc[data_width-1:0];
    end
  end
`else
  logic [data_width-1:0] r_fifo [ROB_DEPTH];
  logic [AW:0]           r_wr_ptr;
  logic [AW:0]           r_rd_ptr;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_en;
  logic                  w_unused_flit;

  assign w_full        = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                         (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty       = (r_wr_ptr == r_rd_ptr);
  assign w_wr_en       = bus.i_valid_noc && !w_full;
  assign w_in_err      = bus.i_valid_noc && w_full;
  assign w_unused_flit = ^bus.i_data_noc[total_width-1:data_width];

  assign bus.o_ready_noc = !w_full;
  assign bus.o_valid_pci = !w_empty;
  assign bus.o_data_pci  = r_fifo[r_rd_ptr[AW-1:0]];

  // FIFO pointers; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_out_acc) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
    end
  end

  // Payload storage in arrival order.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_fifo[r_wr_ptr[AW-1:0]] <= bus.i_data_noc[data_width-1:0];
    end
  end
`endif

endmodule

// File: doc/noc_host_bridge.md
Name: noc_host_bridge

Overview:
- Parametrised host-to-mesh bridge at tile (0,0) of the X*Y processing mesh; successor to the fixed single-PE host interface.
- Ingress: wraps each host word in a NoC flit {dest_x, dest_y, seq, data} and distributes flits round-robin across all worker tiles, excluding (0,0).
- Egress: collects result flits from the mesh and returns them to the host in original issue order through a reorder buffer (ROB).
- Bounds in-flight packets with credit-based flow control.

Parameters:
- X, 8, mesh columns.
- Y, 8, mesh rows; X*Y >= 2.
- pck_num, 12, sequence-number field width.
- data_width, 256, payload width.
- x_size, $clog2(X), x-coordinate width.
- y_size, $clog2(Y), y-coordinate width.
- total_width, x_size+y_size+pck_num+data_width, flit width.
- ROB_DEPTH, 16, maximum outstanding packets; power of 2; ROB_DEPTH <= 2**pck_num.

Ports:
- clk  input  1  clock.
- rstn  input  1  reset; asynchronous, active-low.
- i_valid_pci  input  1  host word valid.
- i_data_pci  input  data_width  host word.
- o_ready_pci  output  1  bridge accepts host word.
- o_valid_pci  output  1  result word valid to host.
- o_data_pci  output  data_width  result word.
- i_ready_pci  input  1  host accepts result.
- o_valid_noc  output  1  flit valid to mesh.
- o_data_noc  output  total_width  flit to mesh.
- i_ready_noc  input  1  mesh accepts flit.
- i_valid_noc  input  1  result flit valid from mesh.
- i_data_noc  input  total_width  result flit.
- o_ready_noc  output  1  bridge accepts result flit.
- o_outstanding  output  $clog2(ROB_DEPTH)+1  packets in flight.
- o_err  output  1  sticky protocol error.

Behaviour:
- Handshake: a transfer occurs on a rising clk edge when valid and ready are both high. Valid, once asserted, holds with stable data until the transfer.
- Flit layout, MSB to LSB: {x[x_size], y[y_size], seq[pck_num], data[data_width]}. Returned flits carry the source coordinates in x/y; the bridge ignores these fields.
- Reset (rstn low, asynchronous):
  - o_valid_noc=0, o_valid_pci=0, o_err=0, o_outstanding=0.
  - ROB valid bits cleared; seq counter, head pointer and destination all reset.
  - After reset: destination=(1,0) if X>1, else (0,1); o_ready_pci=1, o_ready_noc=1.
- Ingress:
  - o_ready_pci = (o_outstanding < ROB_DEPTH) && (!o_valid_noc || i_ready_noc).
  - Accepted host word is registered into o_data_noc with o_valid_noc=1 on the next cycle (latency 1). Full throughput of 1 word/cycle while credits remain and the mesh is ready.
  - Each accept stamps the current seq, then seq increments mod 2**pck_num.
  - Destination advances per accept in row-major order: x increments; at x==X-1, x=0 and y increments. After (X-1,Y-1), wrap to the first non-(0,0) tile. (0,0) is never addressed.
- Credits:
  - o_outstanding +1 on host-side ingress accept.
  - o_outstanding -1 on host-side egress accept (o_valid_pci && i_ready_pci).
  - Both events in the same cycle leave it unchanged.
  - At o_outstanding==ROB_DEPTH, o_ready_pci=0 until a result is delivered.
- Egress (reorder mode):
  - o_ready_noc=1 always; credits guarantee a free slot.
  - Accepted flit is written to slot seq mod ROB_DEPTH and its valid bit is set.
  - Duplicate write to an already-valid slot: flit dropped, o_err set (sticky until reset).
  - Head pointer rd_seq selects the output slot: o_valid_pci = valid[rd_seq mod ROB_DEPTH]; o_data_pci = that slot's payload.
  - A flit written at edge t that is at the head gives o_valid_pci=1 in cycle t+1.
  - On host accept: head valid bit cleared, rd_seq increments (wraps mod 2**pck_num). Write and clear of different slots in the same cycle are both honoured.
  - Out-of-order arrivals wait in the ROB; the head stalls until its own flit arrives.
- Reset mid-operation: all in-flight state is discarded. Flits still inside the mesh are not tracked. Any that return after reset may raise o_err; this is acceptable.

Optional Feature:
- Macro: BRIDGE_REORDER_EN.
- Defined: egress behaves as described above (in-order delivery via ROB).
- Undefined:
  - ROB replaced by a ROB_DEPTH-deep FIFO; results go to the host in arrival order with the seq field ignored.
  - o_ready_noc = FIFO not full.
  - A write attempt while full sets o_err.
  - Credit logic unchanged.

Test Plan:
- After reset, 3 host words A,B,C with i_ready_noc=1 -> flits to (1,0),(2,0),(3,0) with seq 0,1,2, each emitted 1 cycle after its accept.
- X=2,Y=2: 5 host words -> destinations (1,0),(0,1),(1,1),(1,0),(0,1).
- ROB_DEPTH=4, mesh never returns -> exactly 4 accepts, then o_ready_pci=0 and o_outstanding=4; after one result is delivered to the host, o_ready_pci=1.
- Issue seq 0..3, return in order 2,0,3,1 with BRIDGE_REORDER_EN -> host sees payloads for 0,1,2,3. The first o_valid_pci occurs the cycle after seq 0 arrives; 1,2,3 follow on consecutive cycles with i_ready_pci=1.
- Same stimulus without BRIDGE_REORDER_EN -> host sees 2,0,3,1.
- Return seq 1 twice before the head drains -> second copy dropped, o_err=1 and it stays high until rstn low.
